scan_sched: RTL and testbench
=============================

# scan_sched

Ping-pong line-buffer scheduler for the NES-to-VGA scan doubler. Sits between the PPU pixel counters and the doubler's two-bank line RAM. Assigns the write bank and address for each visible PPU line and the read bank for each pair of output lines. Locks the output frame to the PPU frame and detects reader/writer slips.

## Interface
Parameters:
- LINE_W, 256, visible PPU pixels per line (write addresses 0..LINE_W-1)
- VIS_LINES, 240, visible PPU lines per frame
- SLIP_MAX, 2, slips within one frame that force loss of lock

Ports:
- clk  in  1  pixel clock, single clock domain
- reset  in  1  asynchronous, active-high
- count_h  in  9  PPU horizontal counter
- count_v  in  9  PPU vertical counter; 511 is the pre-render line
- out_line_start  in  1  one-cycle pulse at the start of every output line (h==0)
- wr_en  out  1  write strobe to the line RAM
- wr_bank  out  1  bank being written
- wr_addr  out  8  pixel address within bank
- rd_bank  out  1  bank the output side reads
- rd_phase  out  1  0 = first output copy of the line, 1 = second copy
- frame_sync  out  1  one-cycle pulse; output timing resets its h/v counters
- locked  out  1  high while state is LOCKED
- slip  out  1  one-cycle pulse when the reader repeats a line
- slip_count  out  8  saturating slip counter (see Configuration)

## Operation
- Write side: wr_en=1 when count_v<VIS_LINES and count_h<LINE_W. wr_addr=count_h[7:0]. wr_bank toggles after each write of address LINE_W-1, which also sets the complete flag for that bank.
- Frame edge: the block registers count_v. An edge is registered count_v==511 while current count_v==0. On each edge, frame_sync pulses regardless of state, wr_bank resets to 0, all complete flags clear, and the per-frame slip tally clears.
- Read side, in LOCKED only, on each out_line_start:
  - rd_phase toggles.
  - On the 1->0 transition, if the bank other than rd_bank is complete, rd_bank advances to it and its flag clears.
  - If that bank is not complete, rd_bank holds (line repeated), slip pulses, and the tally increments.
- State machine:
  - UNLOCKED → ARMED on a frame edge.
  - ARMED → LOCKED when bank 0 completes. On entry to LOCKED: rd_bank=0, rd_phase=0, bank 0 flag consumed.
  - LOCKED → UNLOCKED when the per-frame tally reaches SLIP_MAX. locked drops in the same cycle as the slip pulse.
  - A frame edge in ARMED or LOCKED re-enters ARMED.
- Outside LOCKED, rd_bank and rd_phase hold their values and out_line_start is ignored.

## Timing
- Reset values: every output is 0, state is UNLOCKED, the registered count_v is 0, and all complete flags are clear. Reset to 0 prevents a false edge on the first 0.
- wr_en, wr_bank and wr_addr are registered with 1-cycle latency from count_h/count_v. The pixel data path must be delayed by one cycle to match.
- Complete flag is set on the cycle after the write of LINE_W-1.
- frame_sync is asserted the cycle after the edge is detected.
- rd_bank, rd_phase and slip are asserted the cycle after out_line_start.
- Simultaneous events:
  - Completion and the advancing out_line_start in the same cycle: counts as complete; advance with no slip.
  - Frame edge and out_line_start in the same cycle: the frame edge wins and the line start is ignored.
- Asserting reset mid-frame immediately returns to the reset values. Relock needs a full 511→0 edge.

## Configuration
- SCAN_SCHED_STATS_EN defined: slip_count increments on every slip, saturates at 255, and clears only on reset.
- SCAN_SCHED_STATS_EN undefined: slip_count is tied to 0 and no counter is built. slip and lock behaviour are unchanged.

## Test plan
- Reset held, then released with count_v=0 → all outputs 0, state UNLOCKED, no frame_sync pulse.
- Sweep count_v 510→511→0 → one frame_sync pulse one cycle after 0 is seen; locked rises only after count_h passes 255 on line 0.
- Locked, one PPU line (341 clks) per two out_line_start pulses → rd_phase toggles 0,1,0,1; rd_bank alternates 0,1,0; slip never pulses.
- Locked, out_line_start pulses at 3 per PPU line → slip pulses; on the second slip in the frame locked drops. slip_count=2 with SCAN_SCHED_STATS_EN, 0 without.
- Bank-complete cycle coincident with the advancing out_line_start → rd_bank advances and slip stays 0.
- Assert reset mid-line while wr_en=1 and locked=1 → next cycle wr_en=0 and locked=0; no relock until a new 511→0 edge.

Source files
------------

// File: rtl/scan_sched_if.sv
// ---------------------------------------------------------------------------
// scan_sched_if
//
// Bundles the PPU-counter inputs and the line-RAM / output-timing controls
// of the scan-doubler line-buffer scheduler.
//
// master : the PPU/timing side (drives counters and output line starts)
// slave  : scan_sched (drives the line RAM controls and lock status)
//
// Signals:
//   count_h, count_v  PPU horizontal / vertical counters (511 = pre-render)
//   out_line_start    one-cycle pulse at the start of every output line
//   wr_en, wr_bank,   line RAM write strobe, bank and pixel address
//   wr_addr
//   rd_bank, rd_phase bank read by the output side, output copy (0/1)
//   frame_sync        one-cycle pulse restarting the output h/v counters
//   locked            output frame is locked to the PPU frame
//   slip              one-cycle pulse when an output line is repeated
//   slip_count        saturating slip statistic (0 unless stats are built)
// ---------------------------------------------------------------------------
interface scan_sched_if;
  logic [8:0] count_h;
  logic [8:0] count_v;
  logic       out_line_start;
  logic       wr_en;
  logic       wr_bank;
  logic [7:0] wr_addr;
  logic       rd_bank;
  logic       rd_phase;
  logic       frame_sync;
  logic       locked;
  logic       slip;
  logic [7:0] slip_count;

  modport master (
    output count_h, count_v, out_line_start,
    input  wr_en, wr_bank, wr_addr, rd_bank, rd_phase,
    input  frame_sync, locked, slip, slip_count
  );

  modport slave (
    input  count_h, count_v, out_line_start,
    output wr_en, wr_bank, wr_addr, rd_bank, rd_phase,
    output frame_sync, locked, slip, slip_count
  );
endinterface

// File: rtl/scan_sched.sv
// ---------------------------------------------------------------------------
// scan_sched
//
// Ping-pong line-buffer scheduler for the NES-to-VGA scan doubler. Each
// visible PPU line is written into one of two line-RAM banks; the output
// side reads every line twice (rd_phase 0/1) and then moves to the other
// bank if it has been completely written. The output frame is locked to the
// PPU frame through frame_sync, and reader/writer slips are counted per
// frame; too many slips in one frame drop the lock.
//
// Ports:
//   clk    pixel clock (single domain)
//   reset  asynchronous, active-high
//   bus    scan_sched_if.slave (PPU counters in, line RAM / lock status out)
//
// Optional feature:
//   SCAN_SCHED_STATS_EN  when defined, slip_count counts every slip and
//                        saturates at 255 (cleared only by reset); when
//                        undefined, slip_count is tied to 0.
// ---------------------------------------------------------------------------
module scan_sched #(
  parameter int LINE_W    = 256,
  parameter int VIS_LINES = 240,
  parameter int SLIP_MAX  = 2
) (
  input  logic         clk,
  input  logic         reset,
  scan_sched_if.slave  bus
);

  localparam logic [8:0] LINE_LIM  = 9'(LINE_W);
  localparam logic [8:0] VIS_LIM   = 9'(VIS_LINES);
  localparam logic [7:0] LAST_ADDR = 8'(LINE_W - 1);
  localparam logic [7:0] SLIP_LIM  = 8'(SLIP_MAX);
  localparam logic [8:0] PRE_LINE  = 9'd511;

  typedef enum logic [1:0] {
    S_UNLOCKED = 2'd0,
    S_ARMED    = 2'd1,
    S_LOCKED   = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic [8:0] r_count_v;
  logic       r_wr_en;
  logic       r_wr_bank;
  logic [7:0] r_wr_addr;
  logic [1:0] r_complete;
  logic       r_rd_bank;
  logic       r_rd_phase;
  logic       r_frame_sync;
  logic       r_slip;
  logic [7:0] r_tally;

  logic       w_edge;
  logic       w_wr_last;
  logic       w_other;
  logic       w_other_ready;
  logic [7:0] w_tally_inc;
  logic       w_lock_entry;
  logic       w_line_step;
  logic       w_advance;
  logic       w_slip;
  logic [1:0] w_set;
  logic [1:0] w_consume;

  // The pre-render line wrapping to line 0 marks a new PPU frame. The
  // registered copy resets to 0 so the first line 0 after reset is not
  // mistaken for a wrap.
  assign w_edge = (r_count_v == PRE_LINE) && (bus.count_v == 9'd0);

  // The write of the last pixel is visible on the registered write outputs;
  // its bank becomes complete on the following clock.
  assign w_wr_last = r_wr_en && (r_wr_addr == LAST_ADDR);

  // A bank that is finishing its last write in this very cycle is treated
  // as already complete, so a line start coinciding with completion still
  // advances instead of slipping.
  assign w_other       = ~r_rd_bank;
  assign w_other_ready = r_complete[w_other] || (w_wr_last && (r_wr_bank == w_other));
  assign w_tally_inc   = r_tally + 8'd1;

  // State register for the lock FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_UNLOCKED;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and read-side decisions. A frame edge always wins over an
  // output line start; line starts only matter while locked, and only the
  // 1->0 phase transition decides between advancing and repeating a line.
  always_comb begin
    w_state_next = r_state;
    w_lock_entry = 1'b0;
    w_line_step  = 1'b0;
    w_advance    = 1'b0;
    w_slip       = 1'b0;
    case (r_state)
      S_UNLOCKED: begin
        if (w_edge) begin
          w_state_next = S_ARMED;
        end
      end
      S_ARMED: begin
        if (w_edge) begin
          w_state_next = S_ARMED;
        end else if (r_complete[0]) begin
          w_state_next = S_LOCKED;
          w_lock_entry = 1'b1;
        end
      end
      S_LOCKED: begin
        if (w_edge) begin
          w_state_next = S_ARMED;
        end else if (bus.out_line_start) begin
          w_line_step = 1'b1;
          if (r_rd_phase) begin
            if (w_other_ready) begin
              w_advance = 1'b1;
            end else begin
              w_slip = 1'b1;
              if (w_tally_inc >= SLIP_LIM) begin
                w_state_next = S_UNLOCKED;
              end
            end
          end
        end
      end
      default: begin
        w_state_next = S_UNLOCKED;
      end
    endcase
  end

  // Per-bank complete flag set/consume requests. Consumption wins so that a
  // bank read in the same cycle it completes is not left marked complete.
  always_comb begin
    w_set     = 2'b00;
    w_consume = 2'b00;
    if (w_wr_last) begin
      w_set[r_wr_bank] = 1'b1;
    end
    if (w_lock_entry) begin
      w_consume[0] = 1'b1;
    end
    if (w_advance) begin
      w_consume[w_other] = 1'b1;
    end
  end

  // Write side, frame tracking, complete flags, slip tally and read side
  // registers. The write controls lag the PPU counters by one clock, so the
  // pixel data path must be delayed by one clock as well.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count_v    <= 9'd0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= 8'd0;
      r_wr_bank    <= 1'b0;
      r_complete   <= 2'b00;
      r_tally      <= 8'd0;
      r_frame_sync <= 1'b0;
      r_slip       <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_rd_phase   <= 1'b0;
    end else begin
      r_count_v    <= bus.count_v;
      r_wr_en      <= (bus.count_v < VIS_LIM) && (bus.count_h < LINE_LIM);
      r_wr_addr    <= bus.count_h[7:0];
      r_frame_sync <= w_edge;
      r_slip       <= w_slip;

      if (w_edge) begin
        r_wr_bank  <= 1'b0;
        r_complete <= 2'b00;
        r_tally    <= 8'd0;
      end else begin
        if (w_wr_last) begin
          r_wr_bank <= ~r_wr_bank;
        end
        r_complete <= (r_complete | w_set) & ~w_consume;
        if (w_slip) begin
          r_tally <= w_tally_inc;
        end
      end

      if (w_lock_entry) begin
        r_rd_bank  <= 1'b0;
        r_rd_phase <= 1'b0;
      end else if (w_line_step) begin
        r_rd_phase <= ~r_rd_phase;
        if (w_advance) begin
          r_rd_bank <= w_other;
        end
      end
    end
  end

  assign bus.wr_en      = r_wr_en;
  assign bus.wr_bank    = r_wr_bank;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.rd_bank    = r_rd_bank;
  assign bus.rd_phase   = r_rd_phase;
  assign bus.frame_sync = r_frame_sync;
  assign bus.slip       = r_slip;
  assign bus.locked     = (r_state == S_LOCKED);

`ifdef SCAN_SCHED_STATS_EN
  logic [7:0] r_slip_count;

  // Lifetime slip statistic: survives frame edges, saturates at 255.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slip_count <= 8'd0;
    end else if (w_slip && (r_slip_count != 8'hFF)) begin
      r_slip_count <= r_slip_count + 8'd1;
    end
  end

  assign bus.slip_count = r_slip_count;
`else
  assign bus.slip_count = 8'd0;
`endif

endmodule

// File: tb/tb_scan_sched.sv
// ---------------------------------------------------------------------------
// tb_scan_sched
//
// Directed self-checking bench for scan_sched. PPU lines are 341 clocks;
// output line starts are placed at chosen horizontal positions. Read-side
// observations after each line start are packed as {rd_bank, rd_phase,
// slip, locked}.
// ---------------------------------------------------------------------------
module tb_scan_sched;

  logic clk = 1'b0;
  logic reset;

  scan_sched_if bus ();

  scan_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] obs [4];
  int n_obs;
  int slip_seen;
  int sync_seen;
  int lock_seen;

`ifdef SCAN_SCHED_STATS_EN
  localparam logic [7:0] EXP_SLIPS_AFTER_SLIP_TEST = 8'd2;
`else
  localparam logic [7:0] EXP_SLIPS_AFTER_SLIP_TEST = 8'd0;
`endif

  // Advance one clock and land just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one full PPU line; pulse out_line_start at the listed h positions
  // (-1 = unused) and record the read-side outputs after each pulse.
  task automatic run_line(input logic [8:0] v, input int p0, input int p1, input int p2);
    n_obs = 0;
    slip_seen = 0;
    sync_seen = 0;
    lock_seen = 0;
    for (int h = 0; h < 341; h++) begin
      bus.count_v = v;
      bus.count_h = 9'(h);
      bus.out_line_start = (h == p0) || (h == p1) || (h == p2);
      tick();
      if (bus.slip) slip_seen++;
      if (bus.frame_sync) sync_seen++;
      if (bus.locked) lock_seen++;
      if (bus.out_line_start && n_obs < 4) begin
        obs[n_obs] = {bus.rd_bank, bus.rd_phase, bus.slip, bus.locked};
        n_obs++;
      end
    end
    bus.out_line_start = 1'b0;
  endtask

  // A few cycles of the pre-render line so the next line 0 forms an edge.
  task automatic pre_render();
    for (int i = 0; i < 3; i++) begin
      bus.count_v = 9'd511;
      bus.count_h = 9'(300 + i);
      bus.out_line_start = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.count_v = 9'd0;
    bus.count_h = 9'd256;
    bus.out_line_start = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.wr_en, bus.wr_bank, bus.wr_addr, bus.rd_bank, bus.rd_phase, bus.frame_sync,
         bus.locked, bus.slip, bus.slip_count} !== 23'd0) begin
      errors++;
      $display("[TB] FAIL reset_held: outputs %b required all zero",
               {bus.wr_en, bus.wr_bank, bus.wr_addr, bus.rd_bank, bus.rd_phase,
                bus.frame_sync, bus.locked, bus.slip, bus.slip_count});
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.wr_en, bus.wr_bank, bus.wr_addr, bus.rd_bank, bus.rd_phase, bus.frame_sync,
           bus.locked, bus.slip, bus.slip_count} !== 23'd0) begin
        errors++;
        $display("[TB] FAIL reset_release cycle %0d: outputs %b required all zero", i,
                 {bus.wr_en, bus.wr_bank, bus.wr_addr, bus.rd_bank, bus.rd_phase,
                  bus.frame_sync, bus.locked, bus.slip, bus.slip_count});
      end
    end
  endtask

  task automatic test_frame_lock();
    logic [7:0] exp_addr;
    for (int i = 0; i < 4; i++) begin
      bus.count_v = (i < 2) ? 9'd510 : 9'd511;
      bus.count_h = 9'(330 + i);
      tick();
      checks++;
      if (bus.frame_sync !== 1'b0 || bus.locked !== 1'b0 || bus.wr_en !== 1'b0) begin
        errors++;
        $display("[TB] FAIL pre_edge %0d: sync/locked/wr_en %b%b%b required 000", i,
                 bus.frame_sync, bus.locked, bus.wr_en);
      end
    end
    for (int h = 0; h < 341; h++) begin
      bus.count_v = 9'd0;
      bus.count_h = 9'(h);
      tick();
      exp_addr = 8'(h);
      checks++;
      if (bus.frame_sync !== (h == 0)) begin
        errors++;
        $display("[TB] FAIL frame_sync h=%0d: got %b required %b", h, bus.frame_sync, (h == 0));
      end
      checks++;
      if (bus.wr_en !== (h < 256) || bus.wr_addr !== exp_addr) begin
        errors++;
        $display("[TB] FAIL write h=%0d: wr_en %b addr %0d required %b %0d", h,
                 bus.wr_en, bus.wr_addr, (h < 256), exp_addr);
      end
      checks++;
      if (bus.wr_bank !== (h >= 256)) begin
        errors++;
        $display("[TB] FAIL wr_bank h=%0d: got %b required %b", h, bus.wr_bank, (h >= 256));
      end
      checks++;
      if (bus.locked !== (h >= 257)) begin
        errors++;
        $display("[TB] FAIL lock_rise h=%0d: got %b required %b", h, bus.locked, (h >= 257));
      end
    end
    checks++;
    if (bus.rd_bank !== 1'b0 || bus.rd_phase !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lock_entry_read: bank/phase %b%b required 00", bus.rd_bank, bus.rd_phase);
    end
  endtask

  task automatic test_locked_lines();
    logic [3:0] e1 [2] = '{4'b0101, 4'b1001};
    logic [3:0] e2 [2] = '{4'b1101, 4'b0001};
    run_line(9'd1, 20, 300, -1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== e1[k]) begin
        errors++;
        $display("[TB] FAIL two_per_line line1 pulse%0d: bank/phase/slip/locked %b required %b", k, obs[k], e1[k]);
      end
    end
    checks++;
    if (slip_seen !== 0) begin
      errors++;
      $display("[TB] FAIL two_per_line line1 slips: got %0d required 0", slip_seen);
    end
    run_line(9'd2, 20, 300, -1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== e2[k]) begin
        errors++;
        $display("[TB] FAIL two_per_line line2 pulse%0d: bank/phase/slip/locked %b required %b", k, obs[k], e2[k]);
      end
    end
    checks++;
    if (slip_seen !== 0 || bus.slip_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL two_per_line line2 slips: got %0d count %0d required 0 0", slip_seen, bus.slip_count);
    end
  endtask

  task automatic test_slip();
    logic [3:0] e1 [3] = '{4'b0101, 4'b0011, 4'b0101};
    logic [3:0] e2 [3] = '{4'b1001, 4'b1101, 4'b1010};
    pre_render();
    run_line(9'd0, -1, -1, -1);
    checks++;
    if (sync_seen !== 1 || bus.locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL slip_relock: syncs %0d locked %b required 1 1", sync_seen, bus.locked);
    end
    run_line(9'd1, 20, 130, 240);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== e1[k]) begin
        errors++;
        $display("[TB] FAIL three_per_line line1 pulse%0d: bank/phase/slip/locked %b required %b", k, obs[k], e1[k]);
      end
    end
    run_line(9'd2, 20, 130, 240);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== e2[k]) begin
        errors++;
        $display("[TB] FAIL three_per_line line2 pulse%0d: bank/phase/slip/locked %b required %b", k, obs[k], e2[k]);
      end
    end
    checks++;
    if (bus.slip_count !== EXP_SLIPS_AFTER_SLIP_TEST) begin
      errors++;
      $display("[TB] FAIL slip_count: got %0d required %0d", bus.slip_count, EXP_SLIPS_AFTER_SLIP_TEST);
    end
    run_line(9'd3, 20, -1, -1);
    checks++;
    if (obs[0] !== 4'b1000 || lock_seen !== 0) begin
      errors++;
      $display("[TB] FAIL unlocked_ignore: bank/phase/slip/locked %b lockcycles %0d required 1000 0", obs[0], lock_seen);
    end
  endtask

  task automatic test_coincident();
    logic [3:0] e1 [2] = '{4'b0101, 4'b1001};
    pre_render();
    run_line(9'd0, -1, -1, -1);
    checks++;
    if (bus.locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL coincident_relock: locked %b required 1", bus.locked);
    end
    run_line(9'd1, 20, 256, -1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== e1[k]) begin
        errors++;
        $display("[TB] FAIL coincident pulse%0d: bank/phase/slip/locked %b required %b", k, obs[k], e1[k]);
      end
    end
    checks++;
    if (slip_seen !== 0) begin
      errors++;
      $display("[TB] FAIL coincident slips: got %0d required 0", slip_seen);
    end
    run_line(9'd2, 20, -1, -1);
    checks++;
    if (obs[0] !== 4'b1101) begin
      errors++;
      $display("[TB] FAIL coincident line2: bank/phase/slip/locked %b required 1101", obs[0]);
    end
    pre_render();
    run_line(9'd0, 0, -1, -1);
    checks++;
    if (obs[0] !== 4'b1100 || sync_seen !== 1) begin
      errors++;
      $display("[TB] FAIL edge_wins: bank/phase/slip/locked %b syncs %0d required 1100 1", obs[0], sync_seen);
    end
    checks++;
    if ({bus.locked, bus.rd_bank, bus.rd_phase} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL edge_relock: locked/bank/phase %b required 100", {bus.locked, bus.rd_bank, bus.rd_phase});
    end
  endtask

  task automatic test_reset_mid();
    int late_locks = 0;
    for (int h = 0; h < 341; h++) begin
      bus.count_v = 9'd1;
      bus.count_h = 9'(h);
      bus.out_line_start = 1'b0;
      tick();
      if (h > 100 && bus.locked) late_locks++;
      if (h == 100) begin
        checks++;
        if (bus.wr_en !== 1'b1 || bus.locked !== 1'b1 || bus.wr_bank !== 1'b1) begin
          errors++;
          $display("[TB] FAIL pre_reset: wr_en/locked/wr_bank %b%b%b required 111", bus.wr_en, bus.locked, bus.wr_bank);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.wr_en, bus.locked, bus.wr_bank, bus.wr_addr, bus.slip_count} !== 19'd0) begin
          errors++;
          $display("[TB] FAIL async_reset: wr_en/locked/wr_bank/addr/count %b required zero",
                   {bus.wr_en, bus.locked, bus.wr_bank, bus.wr_addr, bus.slip_count});
        end
      end
      if (h == 102) reset = 1'b0;
    end
    run_line(9'd2, 20, 300, -1);
    checks++;
    if (late_locks !== 0 || lock_seen !== 0 || slip_seen !== 0) begin
      errors++;
      $display("[TB] FAIL no_relock: locked cycles %0d %0d slips %0d required 0 0 0", late_locks, lock_seen, slip_seen);
    end
    pre_render();
    run_line(9'd0, -1, -1, -1);
    checks++;
    if (bus.locked !== 1'b1 || sync_seen !== 1) begin
      errors++;
      $display("[TB] FAIL relock_after_edge: locked %b syncs %0d required 1 1", bus.locked, sync_seen);
    end
  endtask

  initial begin
    $display("[TB] scan_sched directed bench start");
    test_reset();
    test_frame_lock();
    test_locked_lines();
    test_slip();
    test_coincident();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
